// File: rtl/xpb_reduce_accum.sv
// Sequential xpb reduction: walks the upper square bits one SEG_W window per cycle,
// adding the LUT multiple of 2^pos mod N selected by each window onto the low part.
module xpb_reduce_accum #(
    parameter int SEG_W    = 5,
    parameter int NUM_SEG  = 8,
    parameter int BASE_POS = 520,
    parameter int LUT_W    = 1024,
    parameter int OUT_W    = 1028,
    localparam int CNT_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
    localparam int HI_W    = NUM_SEG * SEG_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BASE_POS-1:0]  lo_in,
    input  logic [HI_W-1:0]      hi_in,
    output logic [CNT_W-1:0]     lut_seg,
    output logic [SEG_W-1:0]     lut_sel,
    input  logic [LUT_W-1:0]     lut_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data
);

    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The accumulator must hold NUM_SEG full-width LUT values plus the low part.
    if ((OUT_W < LUT_W + $clog2(NUM_SEG + 1)) || (OUT_W < BASE_POS)) begin : g_width_check
        $error("xpb_reduce_accum: OUT_W too small for LUT_W/NUM_SEG worst-case sum");
    end

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [HI_W-1:0]    hi_r;
    logic [SEG_W-1:0]   lut_sel_r;
    logic [OUT_W-1:0]   acc_r;
    logic [OUT_W-1:0]   out_data_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [OUT_W-1:0]   sum_s;

    // Running sum including the LUT value returned for the current window.
    always_comb begin
        sum_s = acc_r + OUT_W'(lut_data);
    end

    // Control FSM, window walker and accumulator; every output is a register.
    // hi_r is kept pre-shifted so the next window always sits in its low bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            hi_r        <= '0;
            lut_sel_r   <= '0;
            acc_r       <= '0;
            out_data_r  <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        hi_r       <= hi_in >> SEG_W;
                        lut_sel_r  <= hi_in[SEG_W-1:0];
                        acc_r      <= OUT_W'(lo_in);
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    acc_r <= sum_s;
                    if (cnt_r == LAST_SEG) begin
                        cnt_r       <= '0;
                        lut_sel_r   <= '0;
                        out_data_r  <= sum_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r     <= cnt_r + CNT_W'(1);
                        lut_sel_r <= hi_r[SEG_W-1:0];
                        hi_r      <= hi_r >> SEG_W;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_r       <= '0;
                        out_data_r  <= '0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    lut_sel_r   <= '0;
                    acc_r       <= '0;
                    out_data_r  <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign lut_seg   = cnt_r;
    assign lut_sel   = lut_sel_r;

endmodule

// File: tb/tb_xpb_reduce_accum.sv
// Randomized self-checking bench for xpb_reduce_accum with a behavioural LUT and
// an arithmetic reference model of the reduced sum.
module tb_xpb_reduce_accum;

    localparam int SEG_W    = 5;
    localparam int NUM_SEG  = 8;
    localparam int BASE_POS = 520;
    localparam int LUT_W    = 1024;
    localparam int OUT_W    = 1028;
    localparam int CNT_W    = 3;
    localparam int HI_W     = NUM_SEG * SEG_W;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [BASE_POS-1:0] lo_in;
    logic [HI_W-1:0]     hi_in;
    logic [CNT_W-1:0]    lut_seg;
    logic [SEG_W-1:0]    lut_sel;
    logic [LUT_W-1:0]    lut_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic                lut_mode;

    int n_cmp = 0;
    int n_err = 0;

    xpb_reduce_accum #(
        .SEG_W(SEG_W), .NUM_SEG(NUM_SEG), .BASE_POS(BASE_POS),
        .LUT_W(LUT_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .lo_in(lo_in), .hi_in(hi_in), .lut_seg(lut_seg), .lut_sel(lut_sel),
        .lut_data(lut_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Behavioural LUT bank: (seg+1)*sel normally, all ones for any nonzero select in mode 1.
    always_comb begin
        if (lut_mode) begin
            lut_data = (lut_sel != 5'd0) ? {LUT_W{1'b1}} : {LUT_W{1'b0}};
        end else begin
            lut_data = LUT_W'((int'(lut_seg) + 1) * int'(lut_sel));
        end
    end

    task automatic check(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h..%h expected %h..%h", tag,
                     got[OUT_W-1 -: 64], got[63:0], exp[OUT_W-1 -: 64], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SEG_W-1:0] win(input logic [HI_W-1:0] h, input int k);
        if (k < 0 || k >= NUM_SEG) return '0;
        return h[k*SEG_W +: SEG_W];
    endfunction

    // Reference: lo + sum over windows of the LUT value each window selects.
    function automatic logic [OUT_W-1:0] ref_sum(input logic [HI_W-1:0] h,
                                                 input logic [BASE_POS-1:0] lo,
                                                 input logic mode);
        logic [OUT_W-1:0] s;
        s = OUT_W'(lo);
        for (int k = 0; k < NUM_SEG; k++) begin
            if (mode) begin
                if (win(h, k) != 5'd0) s = s + OUT_W'({LUT_W{1'b1}});
            end else begin
                s = s + OUT_W'((k + 1) * int'(win(h, k)));
            end
        end
        return s;
    endfunction

    function automatic logic [BASE_POS-1:0] rand_lo();
        logic [543:0] t;
        for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
        return t[BASE_POS-1:0];
    endfunction

    function automatic logic [HI_W-1:0] rand_hi();
        logic [63:0] t;
        t = {$urandom, $urandom};
        if ($urandom_range(3, 0) == 0) t[20 +: 10] = 10'd0;
        return t[HI_W-1:0];
    endfunction

    // One full transaction: accept, walk windows, optional stall in DONE, handshake out.
    task automatic run_op(input logic [HI_W-1:0] hi, input logic [BASE_POS-1:0] lo,
                          input logic [OUT_W-1:0] exp, input int stall, input string tag);
        int n;
        check({tag, "_in_ready"}, OUT_W'(in_ready), OUT_W'(1));
        hi_in = hi;
        lo_in = lo;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n <= 40) begin
            check({tag, "_lut"}, OUT_W'({lut_seg, lut_sel}), OUT_W'({CNT_W'(n - 1), win(hi, n - 1)}));
            tick();
            n++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, OUT_W'(out_valid), OUT_W'(1));
            return;
        end
        check({tag, "_latency"}, OUT_W'(n), OUT_W'(NUM_SEG + 1));
        check({tag, "_lut_idle"}, OUT_W'({lut_seg, lut_sel}), OUT_W'(0));
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check({tag, "_hold_valid"}, OUT_W'(out_valid), OUT_W'(1));
            check({tag, "_hold_data"}, out_data, exp);
            check({tag, "_hold_in_ready"}, OUT_W'(in_ready), OUT_W'(0));
            tick();
        end
        out_ready = 1'b1;
        check({tag, "_data"}, out_data, exp);
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, OUT_W'(out_valid), OUT_W'(0));
        check({tag, "_post_in_ready"}, OUT_W'(in_ready), OUT_W'(1));
    endtask

    initial begin
        logic [HI_W-1:0]     h;
        logic [BASE_POS-1:0] l;
        logic [OUT_W-1:0]    e;
        logic [HI_W-1:0]     hq[3];
        logic [BASE_POS-1:0] lq[3];
        logic [OUT_W-1:0]    expq[$];
        int idx, got, cyc, last;
        logic accepted;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; lut_mode = 1'b0;
        hi_in = '0; lo_in = '0;
        tick(); tick();
        check("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
        check("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
        check("rst_out_data", out_data, OUT_W'(0));
        check("rst_lut", OUT_W'({lut_seg, lut_sel}), OUT_W'(0));
        reset = 1'b0;
        tick();

        // Directed cases: zero upper part, all-ones windows, full-width LUT values, long stall.
        run_op('0, BASE_POS'(5), OUT_W'(5), 0, "t1_zero_hi");
        run_op({NUM_SEG{5'h1f}}, '0, OUT_W'(1116), 1, "t2_all_ones");
        lut_mode = 1'b1;
        e = ({4'd0, {LUT_W{1'b1}}} * OUT_W'(8)) + ((OUT_W'(1) << BASE_POS) - OUT_W'(1));
        run_op({NUM_SEG{5'h1f}}, {BASE_POS{1'b1}}, e, 0, "t3_full_width");
        lut_mode = 1'b0;
        h = rand_hi(); l = rand_lo();
        run_op(h, l, ref_sum(h, l, 1'b0), 5, "t4_stall");

        // Abort in the middle of RUN; the next operand must be unaffected.
        h = rand_hi();
        hi_in = h; lo_in = rand_lo(); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("t5_at_cnt3", OUT_W'(lut_seg), OUT_W'(3));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_in_ready", OUT_W'(in_ready), OUT_W'(1));
        check("t5_out_valid", OUT_W'(out_valid), OUT_W'(0));
        check("t5_lut", OUT_W'({lut_seg, lut_sel}), OUT_W'(0));
        h = rand_hi(); l = rand_lo();
        run_op(h, l, ref_sum(h, l, 1'b0), 0, "t5_after_abort");

        // Reset together with in_valid: nothing is captured.
        reset = 1'b1; in_valid = 1'b1; hi_in = '1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < NUM_SEG + 2; i++) tick();
        check("rst_iv_in_ready", OUT_W'(in_ready), OUT_W'(1));
        check("rst_iv_out_valid", OUT_W'(out_valid), OUT_W'(0));

        // Randomized operands, LUT flavours and stalls.
        for (int r = 0; r < 12; r++) begin
            lut_mode = ($urandom_range(2, 0) == 0);
            h = rand_hi(); l = rand_lo();
            e = ref_sum(h, l, lut_mode);
            run_op(h, l, e, int'($urandom_range(3, 0)), $sformatf("rnd%0d", r));
        end
        lut_mode = 1'b0;

        // Back-to-back with in_valid and out_ready held high.
        for (int i = 0; i < 3; i++) begin
            hq[i] = rand_hi();
            lq[i] = rand_lo();
        end
        idx = 0; got = 0; cyc = 0; last = -1;
        hi_in = hq[0]; lo_in = lq[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 60 && got < 3; c++) begin
            accepted = in_valid && in_ready;
            if (accepted) expq.push_back(ref_sum(hi_in, lo_in, 1'b0));
            tick();
            cyc++;
            if (accepted) begin
                idx++;
                if (idx < 3) begin
                    hi_in = hq[idx];
                    lo_in = lq[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("b2b_queue", OUT_W'(expq.size() > 0), OUT_W'(1));
                if (expq.size() > 0) check("b2b_data", out_data, expq.pop_front());
                if (last >= 0) check("b2b_spacing", OUT_W'(cyc - last), OUT_W'(NUM_SEG + 2));
                last = cyc;
                got++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_count", OUT_W'(got), OUT_W'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
